tabuleiro_ultimate: RTL and testbench

Parametrised board engine for Jogão da Velha (ultimate tic-tac-toe). It stores all 81 micro cells and 9 macro cells and validates macro and micro choices. It also detects micro and macro wins and draws, routes the next player to the forced macro, and can optionally pass the turn when a player takes too long. It sits between the button edge-detect/one-hot stage and the `circuito_jogo` display/debug logic, and replaces the hard-wired macro/micro bookkeeping.

---
 rtl/tabuleiro_ultimate.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_tabuleiro_ultimate.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tabuleiro_ultimate.sv
// Board engine for ultimate tic-tac-toe: 81 micro cells, 9 macro cells, move validation,
// win/draw detection and forced-macro routing. Define ULT_MACRO_DRAW_EN to close drawn micro boards.
module tabuleiro_ultimate #(
  parameter bit START_PLAYER   = 1'b0,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iniciar,
  input  logic        botao_valido,
  input  logic [8:0]  botoes,
  output logic        aceita,
  output logic        rejeita,
  output logic        tempo_esgotado,
  output logic        jogador,
  output logic        jogar_macro,
  output logic        jogar_micro,
  output logic [3:0]  macro_atual,
  output logic [17:0] micro_estado,
  output logic [17:0] macro_estado,
  output logic        fim,
  output logic [1:0]  vencedor,
  output logic [3:0]  db_estado
);

  typedef enum logic [3:0] {
    INICIAL        = 4'd0,
    PREPARA        = 4'd1,
    ESPERA_MACRO   = 4'd2,
    ESPERA_MICRO   = 4'd3,
    REGISTRA       = 4'd4,
    VERIFICA_MICRO = 4'd5,
    VERIFICA_MACRO = 4'd6,
    TROCA          = 4'd7,
    FIM            = 4'd15
  } estado_t;

  typedef struct packed {
    logic       ok;
    logic [3:0] idx;
  } sel_t;

  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // The pulse is registered, so the counter fires one cycle before it would reach the limit.
  localparam logic [TW-1:0] TMO_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

  function automatic logic [1:0] trio(input logic [1:0] a, input logic [1:0] b,
                                      input logic [1:0] c);
    return (a == b && b == c && a != 2'b00 && a != 2'b11) ? a : 2'b00;
  endfunction

  function automatic logic [1:0] ganhador(input logic [17:0] t);
    logic [1:0] l [8];
    logic [1:0] g;
    l[0] = trio(t[1:0],   t[3:2],   t[5:4]);
    l[1] = trio(t[7:6],   t[9:8],   t[11:10]);
    l[2] = trio(t[13:12], t[15:14], t[17:16]);
    l[3] = trio(t[1:0],   t[7:6],   t[13:12]);
    l[4] = trio(t[3:2],   t[9:8],   t[15:14]);
    l[5] = trio(t[5:4],   t[11:10], t[17:16]);
    l[6] = trio(t[1:0],   t[9:8],   t[17:16]);
    l[7] = trio(t[5:4],   t[9:8],   t[13:12]);
    g = 2'b00;
    for (int i = 7; i >= 0; i--) begin
      if (l[i] != 2'b00) g = l[i];
    end
    return g;
  endfunction

  function automatic logic cheio(input logic [17:0] t);
    logic c;
    c = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (t[2*k +: 2] == 2'b00) c = 1'b0;
    end
    return c;
  endfunction

  function automatic sel_t decodifica(input logic [8:0] b);
    sel_t s;
    int   n;
    s = '0;
    n = 0;
    for (int k = 0; k < 9; k++) begin
      if (b[k]) begin
        n++;
        s.idx = 4'(k);
      end
    end
    s.ok = (n == 1);
    return s;
  endfunction

  estado_t           r_estado, w_prox;
  logic [8:0][17:0]  r_micro;
  logic [17:0]       r_macro;
  logic              r_jogador;
  logic [3:0]        r_macro_atual;
  logic [3:0]        r_ultima;
  logic [1:0]        r_vencedor;
  logic              r_aceita, r_rejeita, r_tempo;
  logic [TW-1:0]     r_cnt;

  sel_t        w_sel;
  logic [3:0]  w_idx_atual;
  logic [17:0] w_tab_atual;
  logic [1:0]  w_codigo, w_destino, w_cel_macro, w_cel_micro;
  logic [1:0]  w_ganhador_micro, w_ganhador_macro;
  logic        w_espera, w_tmo;

  logic        w_limpa, w_carrega_macro, w_grava_cel, w_fecha_macro, w_limpa_tab;
  logic        w_troca_jog, w_define_atual, w_define_venc;
  logic        w_aceita, w_rejeita, w_tempo;
  logic [1:0]  w_cod_macro, w_cod_venc;
  logic [3:0]  w_novo_atual;

  assign w_sel            = decodifica(botoes);
  assign w_idx_atual      = r_macro_atual - 4'd1;
  assign w_tab_atual      = (r_macro_atual != 4'd0) ? r_micro[w_idx_atual] : '0;
  assign w_codigo         = r_jogador ? 2'b10 : 2'b01;
  assign w_cel_macro      = r_macro[2*w_sel.idx +: 2];
  assign w_cel_micro      = w_tab_atual[2*w_sel.idx +: 2];
  assign w_destino        = r_macro[2*r_ultima +: 2];
  assign w_ganhador_micro = ganhador(w_tab_atual);
  assign w_ganhador_macro = ganhador(r_macro);
  assign w_espera         = (r_estado == ESPERA_MACRO) || (r_estado == ESPERA_MICRO);
  assign w_tmo            = (TIMEOUT_CYCLES > 0) && w_espera && !botao_valido
                            && (r_cnt == TMO_LAST);

  // NOTE: state is updated with non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) r_estado <= INICIAL;
    else       r_estado <= w_prox;
  end

  // NOTE: every control gets a default first, so no path through the case leaves a latch behind.
  always_comb begin
    w_prox          = r_estado;
    w_limpa         = 1'b0;
    w_carrega_macro = 1'b0;
    w_grava_cel     = 1'b0;
    w_fecha_macro   = 1'b0;
    w_cod_macro     = 2'b00;
    w_limpa_tab     = 1'b0;
    w_troca_jog     = 1'b0;
    w_define_atual  = 1'b0;
    w_novo_atual    = 4'd0;
    w_define_venc   = 1'b0;
    w_cod_venc      = 2'b00;
    w_aceita        = 1'b0;
    w_rejeita       = 1'b0;
    w_tempo         = 1'b0;
    case (r_estado)
      INICIAL: if (iniciar) w_prox = PREPARA;
      PREPARA: begin
        w_limpa = 1'b1;
        w_prox  = ESPERA_MACRO;
      end
      ESPERA_MACRO: begin
        if (w_tmo) begin
          w_tempo     = 1'b1;
          w_troca_jog = 1'b1;
        end else if (botao_valido) begin
          if (w_sel.ok && w_cel_macro == 2'b00) begin
            w_carrega_macro = 1'b1;
            w_aceita        = 1'b1;
            w_prox          = ESPERA_MICRO;
          end else begin
            w_rejeita = 1'b1;
          end
        end
      end
      ESPERA_MICRO: begin
        if (w_tmo) begin
          w_tempo     = 1'b1;
          w_troca_jog = 1'b1;
        end else if (botao_valido) begin
          if (w_sel.ok && w_cel_micro == 2'b00) begin
            w_grava_cel = 1'b1;
            w_aceita    = 1'b1;
            w_prox      = REGISTRA;
          end else begin
            w_rejeita = 1'b1;
          end
        end
      end
      REGISTRA: w_prox = VERIFICA_MICRO;
      VERIFICA_MICRO: begin
        if (w_ganhador_micro != 2'b00) begin
          w_fecha_macro = 1'b1;
          w_cod_macro   = w_ganhador_micro;
        end else if (cheio(w_tab_atual)) begin
`ifdef ULT_MACRO_DRAW_EN
          w_fecha_macro = 1'b1;
          w_cod_macro   = 2'b11;
`else
          w_limpa_tab   = 1'b1;
`endif
        end
        w_prox = VERIFICA_MACRO;
      end
      VERIFICA_MACRO: begin
        if (w_ganhador_macro != 2'b00) begin
          w_define_venc = 1'b1;
          w_cod_venc    = w_codigo;
          w_prox        = FIM;
        end else if (cheio(r_macro)) begin
          w_define_venc = 1'b1;
          w_cod_venc    = 2'b11;
          w_prox        = FIM;
        end else begin
          w_prox = TROCA;
        end
      end
      TROCA: begin
        w_troca_jog    = 1'b1;
        w_define_atual = 1'b1;
        if (w_destino == 2'b00) begin
          w_novo_atual = r_ultima + 4'd1;
          w_prox       = ESPERA_MICRO;
        end else begin
          w_novo_atual = 4'd0;
          w_prox       = ESPERA_MACRO;
        end
      end
      FIM:     if (iniciar) w_prox = PREPARA;
      default: w_prox = INICIAL;
    endcase
  end

  // NOTE: the 81-cell store is a packed vector, so reset clears it like any other register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_micro       <= '0;
      r_macro       <= '0;
      r_jogador     <= START_PLAYER;
      r_macro_atual <= 4'd0;
      r_ultima      <= 4'd0;
      r_vencedor    <= 2'b00;
      r_aceita      <= 1'b0;
      r_rejeita     <= 1'b0;
      r_tempo       <= 1'b0;
    end else begin
      r_aceita  <= w_aceita;
      r_rejeita <= w_rejeita;
      r_tempo   <= w_tempo;
      if (w_limpa) begin
        r_micro       <= '0;
        r_macro       <= '0;
        r_jogador     <= START_PLAYER;
        r_macro_atual <= 4'd0;
        r_ultima      <= 4'd0;
        r_vencedor    <= 2'b00;
      end
      if (w_carrega_macro) r_macro_atual <= w_sel.idx + 4'd1;
      if (w_grava_cel) begin
        r_micro[w_idx_atual][2*w_sel.idx +: 2] <= w_codigo;
        r_ultima                               <= w_sel.idx;
      end
      if (w_fecha_macro)  r_macro[2*w_idx_atual +: 2] <= w_cod_macro;
      if (w_limpa_tab)    r_micro[w_idx_atual]        <= '0;
      if (w_troca_jog)    r_jogador                   <= ~r_jogador;
      if (w_define_atual) r_macro_atual               <= w_novo_atual;
      if (w_define_venc)  r_vencedor                  <= w_cod_venc;
    end
  end

  // Idle counter: held at zero outside the wait states, so entering one starts from zero.
  always_ff @(posedge clock) begin
    if (reset || TIMEOUT_CYCLES == 0 || !w_espera || botao_valido || w_tmo) r_cnt <= '0;
    else                                                                      r_cnt <= r_cnt + 1'b1;
  end

  assign aceita         = r_aceita;
  assign rejeita        = r_rejeita;
  assign tempo_esgotado = r_tempo;
  assign jogador        = r_jogador;
  assign jogar_macro    = (r_estado == ESPERA_MACRO);
  assign jogar_micro    = (r_estado == ESPERA_MICRO);
  assign macro_atual    = r_macro_atual;
  assign micro_estado   = w_tab_atual;
  assign macro_estado   = r_macro;
  assign fim            = (r_estado == FIM);
  assign vencedor       = r_vencedor;
  assign db_estado      = r_estado;

endmodule

// File: tb/tb_tabuleiro_ultimate.sv
// Directed bench for tabuleiro_ultimate: a scripted game with hand-computed board values,
// plus a second instance with an 8-cycle turn timeout.
module tb_tabuleiro_ultimate;

`ifdef ULT_MACRO_DRAW_EN
  localparam bit DRAW_EN = 1'b1;
`else
  localparam bit DRAW_EN = 1'b0;
`endif
  localparam logic [17:0] M1_DRAW = DRAW_EN ? 18'h00003 : 18'h00000;

  logic        clock = 1'b0;
  logic        reset, iniciar, botao_valido;
  logic [8:0]  botoes;
  logic        aceita, rejeita, tempo_esgotado, jogador, jogar_macro, jogar_micro, fim;
  logic [3:0]  macro_atual, db_estado;
  logic [17:0] micro_estado, macro_estado;
  logic [1:0]  vencedor;

  logic        iniciar_t, botao_valido_t;
  logic [8:0]  botoes_t;
  logic        aceita_t, rejeita_t, tempo_t, jogador_t, jogar_macro_t, jogar_micro_t, fim_t;
  logic [3:0]  macro_atual_t, db_estado_t;
  logic [17:0] micro_estado_t, macro_estado_t;
  logic [1:0]  vencedor_t;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  tabuleiro_ultimate dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .botao_valido(botao_valido),
    .botoes(botoes), .aceita(aceita), .rejeita(rejeita), .tempo_esgotado(tempo_esgotado),
    .jogador(jogador), .jogar_macro(jogar_macro), .jogar_micro(jogar_micro),
    .macro_atual(macro_atual), .micro_estado(micro_estado), .macro_estado(macro_estado),
    .fim(fim), .vencedor(vencedor), .db_estado(db_estado)
  );

  tabuleiro_ultimate #(.START_PLAYER(1'b0), .TIMEOUT_CYCLES(8)) dut_tmo (
    .clock(clock), .reset(reset), .iniciar(iniciar_t), .botao_valido(botao_valido_t),
    .botoes(botoes_t), .aceita(aceita_t), .rejeita(rejeita_t), .tempo_esgotado(tempo_t),
    .jogador(jogador_t), .jogar_macro(jogar_macro_t), .jogar_micro(jogar_micro_t),
    .macro_atual(macro_atual_t), .micro_estado(micro_estado_t), .macro_estado(macro_estado_t),
    .fim(fim_t), .vencedor(vencedor_t), .db_estado(db_estado_t)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic press_raw(input logic [8:0] b);
    botao_valido = 1'b1;
    botoes       = b;
    tick();
    botao_valido = 1'b0;
    botoes       = '0;
  endtask

  task automatic press(input int k);
    logic [8:0] b;
    b = 9'b1 << (k - 1);
    press_raw(b);
  endtask

  task automatic sel(input int m, input string tag);
    press(m);
    check({tag, ".aceita"}, aceita, 1);
    check({tag, ".macro"}, macro_atual, m);
    check({tag, ".estado"}, db_estado, 3);
  endtask

  // Micro move that does not end the game; samples the next wait state at N+5.
  task automatic mv(input int c, input int exp_macro, input int exp_state, input logic exp_j,
                    input string tag);
    press(c);
    check({tag, ".aceita"}, aceita, 1);
    repeat (4) tick();
    check({tag, ".estado"}, db_estado, exp_state);
    check({tag, ".macro"}, macro_atual, exp_macro);
    check({tag, ".jogador"}, jogador, exp_j);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; iniciar = 1'b0; botao_valido = 1'b0; botoes = '0;
    iniciar_t = 1'b0; botao_valido_t = 1'b0; botoes_t = '0;
    repeat (3) tick();
    check("rst.estado", db_estado, 0);
    check("rst.jogador", jogador, 0);
    check("rst.macro", macro_atual, 0);
    check("rst.macro_estado", macro_estado, 0);
    check("rst.vencedor", vencedor, 0);
    check("rst.pulsos", {aceita, rejeita, tempo_esgotado, jogar_macro, jogar_micro, fim}, 0);
    reset = 1'b0;

    iniciar = 1'b1; tick(); iniciar = 1'b0;
    check("ini.prepara", db_estado, 1);
    tick();
    check("ini.espera", db_estado, 2);
    check("ini.jogar_macro", jogar_macro, 1);

    sel(5, "sel5");
    check("sel5.jogar_micro", jogar_micro, 1);
    mv(4, 4, 3, 1'b1, "x_m5c4");
    mv(5, 5, 3, 1'b0, "o_m4c5");
    mv(6, 6, 3, 1'b1, "x_m5c6");
    mv(5, 5, 3, 1'b0, "o_m6c5");

    // X completes row 4-5-6 of macro 5 with cell 5, which points back at the now-closed macro.
    press(5);
    check("win5.aceita", aceita, 1);
    check("win5.registra", db_estado, 4);
    check("win5.micro", micro_estado, 18'h00540);
    tick();
    check("win5.verif_micro", db_estado, 5);
    check("win5.macro_antes", macro_estado, 0);
    tick();
    check("win5.verif_macro", db_estado, 6);
    check("win5.macro_cel", macro_estado, 18'h00100);
    tick();
    check("win5.troca", db_estado, 7);
    check("win5.jog_antes", jogador, 0);
    tick();
    check("win5.espera", db_estado, 2);
    check("win5.jogador", jogador, 1);
    check("win5.macro", macro_atual, 0);

    press(5);
    check("closed5.rejeita", rejeita, 1);
    check("closed5.aceita", aceita, 0);
    check("closed5.estado", db_estado, 2);
    sel(1, "sel1");
    check("sel1.jogador", jogador, 1);

    mv(1, 1, 3, 1'b0, "o_m1c1");
    check("o_m1c1.micro", micro_estado, 18'h00002);
    press(1);
    check("occ.rejeita", rejeita, 1);
    check("occ.estado", db_estado, 3);
    press_raw(9'b000000011);
    check("two.rejeita", rejeita, 1);
    press_raw(9'b000000000);
    check("zero.rejeita", rejeita, 1);
    check("rej.micro", micro_estado, 18'h00002);
    check("rej.jogador", jogador, 0);

    // Fill micro board 1 to a draw: O on 1,3,6,7,8 and X on 2,4,5,9.
    mv(2, 2, 3, 1'b1, "f1");
    mv(3, 3, 3, 1'b0, "f2");
    mv(1, 1, 3, 1'b1, "f3");
    mv(3, 3, 3, 1'b0, "f4");
    mv(2, 2, 3, 1'b1, "f5");
    mv(1, 1, 3, 1'b0, "f6");
    mv(4, 4, 3, 1'b1, "f7");
    mv(1, 1, 3, 1'b0, "f8");
    mv(5, 0, 2, 1'b1, "f9");
    sel(1, "f10");
    mv(6, 6, 3, 1'b0, "f11");
    mv(1, 1, 3, 1'b1, "f12");
    mv(7, 7, 3, 1'b0, "f13");
    mv(1, 1, 3, 1'b1, "f14");
    mv(8, 8, 3, 1'b0, "f15");
    mv(9, 9, 3, 1'b1, "f16");
    mv(1, 1, 3, 1'b0, "f17");
    check("fill.micro8", micro_estado, 18'h0A966);
    press(9);
    check("draw.aceita", aceita, 1);
    check("draw.micro_full", micro_estado, 18'h1A966);
    repeat (2) tick();
    check("draw.macro", macro_estado, 18'h00100 | M1_DRAW);
    check("draw.micro", micro_estado, DRAW_EN ? 18'h1A966 : 18'h00000);
    repeat (2) tick();
    check("draw.estado", db_estado, 3);
    check("draw.next_macro", macro_atual, 9);
    check("draw.jogador", jogador, 1);
    check("draw.micro9", micro_estado, 18'h00002);

    // X takes macros 3 and 7 to complete the 3-5-7 diagonal.
    mv(3, 3, 3, 1'b0, "g1");
    mv(3, 0, 2, 1'b1, "g2");
    check("g2.macro", macro_estado, 18'h00110 | M1_DRAW);
    sel(2, "g3");
    mv(7, 7, 3, 1'b0, "g4");
    mv(4, 4, 3, 1'b1, "g5");
    mv(7, 7, 3, 1'b0, "g6");
    press(7);
    check("fin.aceita", aceita, 1);
    repeat (2) tick();
    check("fin.macro", macro_estado, 18'h01110 | M1_DRAW);
    tick();
    check("fin.estado", db_estado, 15);
    check("fin.fim", fim, 1);
    check("fin.vencedor", vencedor, 2'b01);
    check("fin.jogar_micro", jogar_micro, 0);

    press(4);
    check("fim.ign_pulsos", {aceita, rejeita}, 0);
    check("fim.ign_estado", db_estado, 15);
    iniciar = 1'b1; tick(); iniciar = 1'b0;
    check("reini.prepara", db_estado, 1);
    tick();
    check("reini.espera", db_estado, 2);
    check("reini.macro", macro_estado, 0);
    check("reini.vencedor", vencedor, 0);
    check("reini.fim", fim, 0);
    check("reini.jogador", jogador, 0);
    sel(7, "reini7");
    check("reini.micro7", micro_estado, 0);

    press(1);
    check("mid.registra", db_estado, 4);
    reset = 1'b1;
    tick();
    check("mid.estado", db_estado, 0);
    check("mid.macro", macro_atual, 0);
    check("mid.aceita", aceita, 0);
    check("mid.macro_estado", macro_estado, 0);
    check("mid.jogador", jogador, 0);
    reset = 1'b0;

    iniciar_t = 1'b1; tick(); iniciar_t = 1'b0;
    check("tmo.prepara", db_estado_t, 1);
    tick();
    check("tmo.entrada", db_estado_t, 2);
    repeat (7) tick();
    check("tmo.cedo", tempo_t, 0);
    check("tmo.jog_cedo", jogador_t, 0);
    tick();
    check("tmo.pulso", tempo_t, 1);
    check("tmo.jogador", jogador_t, 1);
    check("tmo.estado", db_estado_t, 2);
    check("tmo.macro", macro_atual_t, 0);
    tick();
    check("tmo.pulso_fim", tempo_t, 0);

    botao_valido_t = 1'b1; botoes_t = 9'b000010000; tick();
    botao_valido_t = 1'b0; botoes_t = '0;
    check("tmo2.aceita", aceita_t, 1);
    check("tmo2.macro", macro_atual_t, 5);
    repeat (7) tick();
    check("tmo2.cedo", tempo_t, 0);
    tick();
    check("tmo2.pulso", tempo_t, 1);
    check("tmo2.jogador", jogador_t, 0);
    check("tmo2.macro_mantido", macro_atual_t, 5);
    check("tmo2.estado", db_estado_t, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
